// File: rtl/jtbubl_rom_slot.sv
// One-entry ROM cache slot: serves 32-bit words to a client and refills
// from SDRAM as two 16-bit beats on a miss.
module jtbubl_rom_slot #(
  parameter int unsigned AW     = 18,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          downloading,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [31:0]   rom_data,
  output logic          rom_ok,
  output logic          sdram_req,
  output logic [21:0]   sdram_addr,
  input  logic          sdram_gnt,
  input  logic          sdram_dst,
  input  logic [15:0]   sdram_data
);

  localparam int unsigned SDW = 22;

  typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   tag, tag_nxt;
  logic [AW-1:0]   fetch_addr, fetch_addr_nxt;
  logic            valid, valid_nxt;
  logic [31:0]     data, data_nxt;
  logic            req_nxt;
  logic [SDW-1:0]  saddr_nxt;
  logic            hit;

  // Cache lookup; rom_ok is deliberately combinational so hits cost no cycle
  assign hit      = valid && (rom_addr == tag);
  assign rom_ok   = rom_cs & hit & ~downloading;
  assign rom_data = data;

  // Next-state and next-register values
  always_comb begin
    state_nxt      = state;
    tag_nxt        = tag;
    fetch_addr_nxt = fetch_addr;
    valid_nxt      = valid;
    data_nxt       = data;
    req_nxt        = sdram_req;
    saddr_nxt      = sdram_addr;
    case (state)
      IDLE: begin
        if (rom_cs && !downloading && !hit) begin
          fetch_addr_nxt = rom_addr;
          saddr_nxt      = OFFSET + SDW'(rom_addr);
          valid_nxt      = 1'b0;
          req_nxt        = 1'b1;
          state_nxt      = REQ;
        end
      end
      REQ: begin
        if (sdram_gnt) begin
          req_nxt = 1'b0;
          if (sdram_dst) begin
            // First beat may arrive together with the grant
            data_nxt[15:0] = sdram_data;
            state_nxt      = BEAT1;
          end else begin
            state_nxt = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (sdram_dst) begin
          data_nxt[15:0] = sdram_data;
          state_nxt      = BEAT1;
        end
      end
      BEAT1: begin
        if (sdram_dst) begin
          data_nxt[31:16] = sdram_data;
          tag_nxt         = fetch_addr;
          valid_nxt       = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A ROM download invalidates the slot and abandons any fetch in flight
    if (downloading) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
      req_nxt   = 1'b0;
      data_nxt  = data;
      tag_nxt   = tag;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tag        <= '0;
      fetch_addr <= '0;
      valid      <= 1'b0;
      data       <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= OFFSET;
    end else begin
      state      <= state_nxt;
      tag        <= tag_nxt;
      fetch_addr <= fetch_addr_nxt;
      valid      <= valid_nxt;
      data       <= data_nxt;
      sdram_req  <= req_nxt;
      sdram_addr <= saddr_nxt;
    end
  end

endmodule

// File: tb/tb_jtbubl_rom_slot.sv
// Self-checking bench for jtbubl_rom_slot: directed scenarios plus a
// randomized run against a one-entry cache model.
module tb_jtbubl_rom_slot;

  localparam logic [21:0] OFF  = 22'h10000;
  localparam logic [21:0] WOFF = 22'h3FFFFF;

  logic        rst, clk, downloading, rom_cs;
  logic [17:0] rom_addr;
  logic        sdram_gnt, sdram_dst;
  logic [15:0] sdram_data;
  logic [31:0] rom_data, w_rom_data;
  logic        rom_ok, w_rom_ok, sdram_req, w_sdram_req;
  logic [21:0] sdram_addr, w_sdram_addr;

  int errors = 0;
  int checks = 0;

  // Model of the cache contents, kept by the bench
  logic        m_valid;
  logic [17:0] m_tag;
  logic [31:0] m_data;

  jtbubl_rom_slot #(.AW(18), .OFFSET(OFF)) u_dut (
    .rst(rst), .clk(clk), .downloading(downloading), .rom_cs(rom_cs),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_gnt(sdram_gnt),
    .sdram_dst(sdram_dst), .sdram_data(sdram_data)
  );

  // Second slot with an offset that forces address wrap-around
  jtbubl_rom_slot #(.AW(18), .OFFSET(WOFF)) u_wrap (
    .rst(rst), .clk(clk), .downloading(downloading), .rom_cs(rom_cs),
    .rom_addr(rom_addr), .rom_data(w_rom_data), .rom_ok(w_rom_ok),
    .sdram_req(w_sdram_req), .sdram_addr(w_sdram_addr), .sdram_gnt(sdram_gnt),
    .sdram_dst(sdram_dst), .sdram_data(sdram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full miss: bench plays the SDRAM with the given grant delay and beat gap
  task automatic do_fetch(input logic [17:0] a, input int gdly, input int gap,
                          input bit coinc, input logic [15:0] lo, input logic [15:0] hi);
    logic [21:0] ea, ew;
    ea = OFF + {4'b0, a};
    ew = WOFF + {4'b0, a};
    rom_cs = 1'b1; rom_addr = a; sdram_gnt = 1'b0; sdram_dst = 1'b0;
    #1;
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL miss_ok: got %b want 0 (addr %h)", rom_ok, a); end
    step();
    checks++; if (sdram_req !== 1'b1) begin errors++; $display("FAIL req_high: got %b want 1", sdram_req); end
    checks++; if (sdram_addr !== ea) begin errors++; $display("FAIL sdram_addr: got %h want %h", sdram_addr, ea); end
    checks++; if (w_sdram_addr !== ew) begin errors++; $display("FAIL wrap_addr: got %h want %h", w_sdram_addr, ew); end
    for (int i = 0; i < gdly; i++) begin
      step();
      checks++; if (sdram_req !== 1'b1 || sdram_addr !== ea) begin errors++; $display("FAIL req_hold: got %b/%h want 1/%h", sdram_req, sdram_addr, ea); end
    end
    sdram_gnt = 1'b1;
    if (coinc) begin sdram_dst = 1'b1; sdram_data = lo; end
    step();
    sdram_gnt = 1'b0; sdram_dst = 1'b0;
    checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL req_drop: got %b want 0", sdram_req); end
    if (!coinc) begin
      repeat (gap) step();
      sdram_dst = 1'b1; sdram_data = lo;
      step();
      sdram_dst = 1'b0;
    end
    repeat (gap) step();
    sdram_dst = 1'b1; sdram_data = hi;
    #1;
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL early_ok: got %b want 0", rom_ok); end
    step();
    sdram_dst = 1'b0; sdram_data = 16'(($urandom));
    #1;
    checks++; if (rom_ok !== 1'b1) begin errors++; $display("FAIL fill_ok: got %b want 1", rom_ok); end
    checks++; if (rom_data !== {hi, lo}) begin errors++; $display("FAIL fill_data: got %h want %h", rom_data, {hi, lo}); end
    m_valid = 1'b1; m_tag = a; m_data = {hi, lo};
  endtask

  task automatic test_reset();
    rst = 1'b1; downloading = 1'b0; rom_cs = 1'b1; rom_addr = 18'h0;
    sdram_gnt = 1'b0; sdram_dst = 1'b0; sdram_data = 16'h0;
    m_valid = 1'b0; m_tag = '0; m_data = '0;
    repeat (3) step();
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL rst_ok: got %b want 0", rom_ok); end
    checks++; if (rom_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", rom_data); end
    checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", sdram_req); end
    checks++; if (sdram_addr !== OFF) begin errors++; $display("FAIL rst_addr: got %h want %h", sdram_addr, OFF); end
    checks++; if (w_sdram_addr !== WOFF) begin errors++; $display("FAIL rst_waddr: got %h want %h", w_sdram_addr, WOFF); end
    rom_cs = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_miss();
    do_fetch(18'h00124, 0, 0, 1'b0, 16'hBEEF, 16'hCAFE);
  endtask

  task automatic test_hit();
    rom_cs = 1'b1; rom_addr = 18'h00124;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rom_ok !== 1'b1 || rom_data !== 32'hCAFEBEEF) begin errors++; $display("FAIL hit: got %b/%h want 1/cafebeef", rom_ok, rom_data); end
      step();
      checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL hit_req: got %b want 0", sdram_req); end
    end
  endtask

  task automatic test_addr_change();
    downloading = 1'b1; step(); downloading = 1'b0;
    rom_cs = 1'b1; rom_addr = 18'h00124;
    step();
    sdram_gnt = 1'b1; step(); sdram_gnt = 1'b0;
    rom_addr = 18'h00200; sdram_dst = 1'b1; sdram_data = 16'h1111; step();
    sdram_data = 16'h2222; step(); sdram_dst = 1'b0;
    #1;
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL chg_ok: got %b want 0", rom_ok); end
    checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL chg_idle: got %b want 0", sdram_req); end
    rom_addr = 18'h00124; #1;
    checks++; if (rom_ok !== 1'b1 || rom_data !== 32'h22221111) begin errors++; $display("FAIL chg_tag: got %b/%h want 1/22221111", rom_ok, rom_data); end
    rom_addr = 18'h00200; #1;
    step();
    checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h10200) begin errors++; $display("FAIL chg_req2: got %b/%h want 1/10200", sdram_req, sdram_addr); end
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL chg_ok2: got %b want 0", rom_ok); end
    sdram_gnt = 1'b1; step(); sdram_gnt = 1'b0;
    sdram_dst = 1'b1; sdram_data = 16'h3333; step();
    sdram_data = 16'h4444; step(); sdram_dst = 1'b0;
    #1;
    checks++; if (rom_ok !== 1'b1 || rom_data !== 32'h44443333) begin errors++; $display("FAIL chg_fill2: got %b/%h want 1/44443333", rom_ok, rom_data); end
  endtask

  task automatic test_coincident();
    do_fetch(18'h00777, 0, 0, 1'b1, 16'h5A5A, 16'hA5A5);
    do_fetch(18'h00778, 2, 1, 1'b1, 16'h0123, 16'h4567);
  endtask

  task automatic test_wrap();
    rom_cs = 1'b1; rom_addr = 18'h00002;
    step();
    checks++; if (w_sdram_req !== 1'b1 || w_sdram_addr !== 22'h000001) begin errors++; $display("FAIL wrap: got %b/%h want 1/000001", w_sdram_req, w_sdram_addr); end
    sdram_gnt = 1'b1; step(); sdram_gnt = 1'b0;
    sdram_dst = 1'b1; sdram_data = 16'h0001; step();
    sdram_data = 16'h0002; step(); sdram_dst = 1'b0;
    #1;
    checks++; if (w_rom_ok !== 1'b1 || w_rom_data !== 32'h00020001) begin errors++; $display("FAIL wrap_fill: got %b/%h want 1/00020001", w_rom_ok, w_rom_data); end
  endtask

  task automatic test_abort_download();
    rom_cs = 1'b1; rom_addr = 18'h00050;
    step();
    sdram_gnt = 1'b1; step(); sdram_gnt = 1'b0;
    sdram_dst = 1'b1; sdram_data = 16'hDEAD; step();
    sdram_data = 16'hBAD0; downloading = 1'b1; #1;
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL dl_ok: got %b want 0", rom_ok); end
    step();
    checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL dl_req: got %b want 0", sdram_req); end
    step();
    sdram_dst = 1'b0; downloading = 1'b0; #1;
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL dl_valid: got %b want 0", rom_ok); end
    do_fetch(18'h00050, 0, 0, 1'b0, 16'h1234, 16'h5678);
  endtask

  task automatic test_abort_reset();
    rom_cs = 1'b1; rom_addr = 18'h00060;
    step();
    sdram_gnt = 1'b1; step(); sdram_gnt = 1'b0;
    sdram_dst = 1'b1; sdram_data = 16'h7777; step();
    sdram_data = 16'h8888; rst = 1'b1; #1;
    checks++; if (rom_ok !== 1'b0 || rom_data !== 32'h0) begin errors++; $display("FAIL rst2_out: got %b/%h want 0/0", rom_ok, rom_data); end
    checks++; if (sdram_req !== 1'b0 || sdram_addr !== OFF) begin errors++; $display("FAIL rst2_req: got %b/%h want 0/%h", sdram_req, sdram_addr, OFF); end
    step();
    rst = 1'b0; rom_cs = 1'b0;
    step();
    sdram_dst = 1'b0;
    checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL rst2_late: got %b want 0", sdram_req); end
    rom_cs = 1'b1; #1;
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL rst2_valid: got %b want 0", rom_ok); end
    do_fetch(18'h00060, 1, 0, 1'b0, 16'h9999, 16'hAAAA);
  endtask

  task automatic test_random();
    logic [17:0] pool [4];
    logic [17:0] a;
    pool[0] = 18'h00010; pool[1] = 18'h00011; pool[2] = 18'h3FFFF; pool[3] = 18'h20000;
    downloading = 1'b1; step(); downloading = 1'b0;
    m_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      a = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 4) == 0) begin
        rom_cs = 1'b0; #1;
        checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL rnd_cs: got %b want 0", rom_ok); end
        step();
      end
      if (m_valid && a == m_tag) begin
        rom_cs = 1'b1; rom_addr = a; #1;
        checks++; if (rom_ok !== 1'b1 || rom_data !== m_data) begin errors++; $display("FAIL rnd_hit: got %b/%h want 1/%h", rom_ok, rom_data, m_data); end
        step();
        checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL rnd_hit_req: got %b want 0", sdram_req); end
      end else begin
        do_fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_miss();
    test_hit();
    test_addr_change();
    test_coincident();
    test_wrap();
    test_abort_download();
    test_abort_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jtbubl_rom_slot.md
JTBUBL_ROM_SLOT -- requirements
Module: jtbubl_rom_slot

Interface
REQ-001 Parameters SHALL be: AW, default 18, client address width; OFFSET, default 22'h0, SDRAM word offset of this slot.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- rst, input, 1: asynchronous, active-high reset.
- clk, input, 1: clock.
- downloading, input, 1: ROM load in progress.
- rom_cs, input, 1: client request.
- rom_addr, input, AW: client 16-bit-word address.
- rom_data, output, 32: fetched data.
- rom_ok, output, 1: rom_data valid for the current rom_addr.
- sdram_req, output, 1: fetch request.
- sdram_addr, output, 22: SDRAM word address.
- sdram_gnt, input, 1: request accepted.
- sdram_dst, input, 1: data beat strobe for this slot.
- sdram_data, input, 16: beat data.
REQ-003 Reset SHALL be rst, asynchronous, active-high; the clock SHALL be clk.

Function
REQ-004 The block SHALL hold a one-entry cache consisting of tag[AW-1:0], valid and data[31:0], with rom_data driven directly from data.
REQ-005 rom_ok SHALL be combinational: rom_ok = rom_cs & valid & (rom_addr == tag) & ~downloading.
REQ-006 The FSM SHALL have four states: IDLE, REQ, BEAT0, BEAT1.
REQ-007 In IDLE, on rom_cs & ~downloading & ~hit, the FSM SHALL:
- latch rom_addr into the fetch address;
- clear valid;
- set sdram_req=1;
- move to REQ.
REQ-008 In REQ, sdram_req SHALL stay high until a cycle with sdram_gnt=1; in that cycle sdram_req SHALL drop and the FSM SHALL move to BEAT0.
REQ-009 If sdram_gnt and sdram_dst are high in the same REQ cycle, the block SHALL capture the low half and move directly to BEAT1.
REQ-010 In BEAT0, sdram_dst SHALL load sdram_data into data[15:0] and move to BEAT1; otherwise the FSM SHALL wait indefinitely.
REQ-011 In BEAT1, sdram_dst SHALL:
- load data[31:16];
- set tag to the fetch address;
- set valid=1;
- move to IDLE.
rom_ok SHALL rise in the following cycle if rom_addr still matches.
REQ-012 sdram_dst SHALL be ignored in IDLE, and in REQ unless sdram_gnt is high in the same cycle.
REQ-013 sdram_addr SHALL equal OFFSET + zero-extended fetch address, computed modulo 2^22 with wrap-around and no error flag, and SHALL be stable whenever sdram_req=1.
REQ-014 Minimum miss latency SHALL be 4 cycles from rom_cs to rom_ok, assuming gnt in the cycle after req and back-to-back dst beats.
REQ-015 If rom_addr changes or rom_cs drops mid-fetch, the fetch SHALL complete for the latched address and fill the cache.
- A mismatching request SHALL start a new fetch from IDLE the cycle after completion.
- rom_ok SHALL remain 0 for the new address until its own fetch completes.
REQ-016 On a hit in IDLE, no SDRAM request SHALL be issued.
REQ-017 While downloading=1, the block SHALL:
- force valid=0;
- force sdram_req=0;
- force the FSM to IDLE within one cycle, abandoning any fetch;
- ignore sdram_dst.
REQ-018 Back-to-back misses SHALL be separated by exactly one IDLE cycle.

Reset
REQ-019 While rst=1, the block SHALL hold:
- FSM=IDLE;
- valid=0;
- tag=0;
- data=0 (so rom_data=0);
- sdram_req=0;
- sdram_addr=OFFSET;
- rom_ok=0.
REQ-020 Reset asserted mid-fetch SHALL abort the fetch; after release, pending beats SHALL be ignored until a new request is granted.

Verification
REQ-021 Basic miss: OFFSET=22'h10000, rom_cs=1, rom_addr=18'h00124; gnt one cycle after req; dst with 16'hBEEF then 16'hCAFE on consecutive cycles -> sdram_addr=22'h10124, rom_data=32'hCAFEBEEF, rom_ok=1 four cycles after rom_cs.
REQ-022 Hit: repeat rom_addr=18'h00124 after fill -> rom_ok=1 in the same cycle, sdram_req remains 0.
REQ-023 Address change mid-fetch: switch rom_addr to 18'h00200 during BEAT0 -> first fetch completes (tag=18'h00124), rom_ok stays 0, second sdram_req issued with sdram_addr=22'h10200 after one IDLE cycle.
REQ-024 Coincident gnt and dst: gnt and the first dst in the same cycle -> low half captured, FSM in BEAT1, correct 32-bit result.
REQ-025 Wrap: OFFSET=22'h3FFFFF, rom_addr=18'h00002 -> sdram_addr=22'h000001.
REQ-026 Abort: assert downloading (then separately rst) during BEAT1 -> sdram_req=0, valid=0, rom_ok=0, a late dst is ignored, the next rom_cs re-fetches.
